// File: rtl/reg_arb_rr.sv
`default_nettype none
// =============================================================================
// reg_arb_rr : round-robin arbiter feeding a single-entry val/rdy output register
// Rev 1.0
// =============================================================================
module reg_arb_rr #(
    parameter int p_nreqs = 2,
    parameter int p_nbits = 32,
    parameter int p_sbits = $clog2(p_nreqs)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [p_nreqs-1:0]         req_val,
    output logic [p_nreqs-1:0]         req_rdy,
    input  logic [p_nreqs*p_nbits-1:0] req_msg,
    output logic                       resp_val,
    input  logic                       resp_rdy,
    output logic [p_nbits-1:0]         resp_msg,
    output logic [p_sbits-1:0]         resp_src
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [p_sbits-1:0] prio_q,  prio_d;
    logic [p_sbits-1:0] src_q,   src_d;
    logic [p_nbits-1:0] msg_q,   msg_d;

    logic [p_nbits-1:0] msg_arr [p_nreqs];
    logic               win_found;
    logic [p_sbits-1:0] win_idx;
    logic [p_sbits:0]   cand;
    logic [p_sbits:0]   prio_inc;
    logic               can_accept;
    logic               enq;
    logic               deq;

    generate
        for (genvar g = 0; g < p_nreqs; g++) begin : g_unpack
            assign msg_arr[g] = req_msg[g*p_nbits +: p_nbits];
        end
    endgenerate

    // Scan from prio upward with wrap; the extra bit keeps prio+k from overflowing.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < p_nreqs; k++) begin
            cand = {1'b0, prio_q} + (p_sbits+1)'(k);
            if (cand >= (p_sbits+1)'(p_nreqs)) begin
                cand = cand - (p_sbits+1)'(p_nreqs);
            end
            if (!win_found && req_val[cand[p_sbits-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[p_sbits-1:0];
            end
        end
    end

    assign can_accept = (state_q == EMPTY) || resp_rdy;
    assign enq        = can_accept && win_found;
    assign deq        = (state_q == FULL) && resp_rdy;
    assign prio_inc   = {1'b0, win_idx} + (p_sbits+1)'(1);

    // rst gates the grant so no requester sees a handshake while reset is held.
    always_comb begin
        req_rdy = '0;
        if (rst && enq) begin
            req_rdy[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        src_d   = src_q;
        msg_d   = msg_q;
        if (enq) begin
            state_d = FULL;
            msg_d   = msg_arr[win_idx];
            src_d   = win_idx;
            prio_d  = (prio_inc == (p_sbits+1)'(p_nreqs)) ? '0 : prio_inc[p_sbits-1:0];
        end else if (deq) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            prio_q  <= '0;
            src_q   <= '0;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            src_q   <= src_d;
            msg_q   <= msg_d;
        end
    end

    assign resp_val = (state_q == FULL);
    assign resp_msg = msg_q;
    assign resp_src = src_q;

endmodule
`default_nettype wire

// File: doc/reg_arb_rr.md
# reg_arb_rr

Round-robin arbiter sharing one pipeline register between `p_nreqs` val/rdy requesters, e.g. several units competing for a single memory-request or writeback path in the TinyRV1 datapath. Each cycle it selects at most one valid requester and captures its message into a single-entry output register. It then presents that message downstream with a val/rdy handshake and rotates priority so no requester starves.

## Interface
- `p_nreqs`, default 2: number of requesters, legal range 2..8.
- `p_nbits`, default 32: message width in bits.
- `p_sbits`, default `$clog2(p_nreqs)`: source-index width. Derived; do not override.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset, **asynchronous, active-low**. Asserts immediately on falling `rst`; deasserts synchronously to `clk`.
- `req_val`  in  `p_nreqs`: per-requester valid.
- `req_rdy`  out  `p_nreqs`: per-requester ready; at most one bit is high.
- `req_msg`  in  `p_nreqs*p_nbits`: requester i occupies bits `[i*p_nbits +: p_nbits]`.
- `resp_val`  out  1: output register holds a message.
- `resp_rdy`  in  1: downstream accepts the message.
- `resp_msg`  out  `p_nbits`: buffered message.
- `resp_src`  out  `p_sbits`: index of the requester that produced `resp_msg`.

## Operation
- State: `full` bit (EMPTY/FULL), `prio` pointer (`p_sbits`), and the output register holding `resp_msg`/`resp_src`.
- `can_accept = !full || resp_rdy`.
  - EMPTY accepts.
  - FULL accepts only in a cycle where the current message is dequeued, which allows back-to-back throughput of one message per cycle.
- Grant selection:
  - The winner is the first i with `req_val[i]=1`, scanning `prio, prio+1, ..., p_nreqs-1, 0, ..., prio-1`.
  - `req_rdy[i] = can_accept && (i == winner)`.
  - No `req_val` high means no grant and all `req_rdy` low.
- Enqueue happens when `req_val[w] && req_rdy[w]`. At the clock edge:
  - the output register loads `req_msg[w]`;
  - `resp_src` loads `w`;
  - `full` is set to 1;
  - `prio` loads `(w+1) mod p_nreqs`. This must wrap correctly for a non-power-of-two `p_nreqs`.
- Dequeue (`resp_val && resp_rdy`) with no enqueue in the same cycle: `full` becomes 0. `resp_msg` and `resp_src` hold their stale values and must not be sampled.
- Simultaneous enqueue and dequeue while FULL: the new message replaces the old one and `full` stays 1.
- `prio` changes only on enqueue. Idle cycles and stalled cycles (FULL with `resp_rdy=0`) leave it unchanged.
- `resp_val = full`.
- Downstream may hold `resp_rdy` high while `resp_val` is low; this has no effect.
- Requesters must hold `req_val`/`req_msg` stable until they see `req_rdy`. The arbiter may move the grant to a different requester between cycles, but only after an enqueue.
- State transitions:
  - EMPTY→FULL on enqueue.
  - FULL→EMPTY on dequeue without enqueue.
  - FULL→FULL on stall, or on simultaneous enqueue and dequeue.
  - EMPTY→EMPTY when there is no valid requester.

## Timing
- Reset values: `full=0`, `prio=0`, `resp_val=0`, `resp_msg=0`, `resp_src=0`, `req_rdy=0` throughout reset.
- Reset asserted mid-operation discards any buffered message. `resp_val` drops without waiting for a clock edge.
- Latency: a message enqueued at edge N is visible on `resp_msg`, with `resp_val=1`, immediately after edge N. That is one cycle from handshake to output.
- Throughput: one message per cycle when downstream holds `resp_rdy=1`.
- Combinational paths:
  - `req_rdy` depends on `req_val`, `resp_rdy`, `full` and `prio`.
  - `resp_val`, `resp_msg` and `resp_src` are registered outputs only.
- Fairness: a requester that holds `req_val` is granted within `p_nreqs` enqueues.

## Test plan
- Reset: pulse `rst` low while FULL holding 0xDEADBEEF. Required: `resp_val=0`, `resp_msg=0`, `resp_src=0` and all `req_rdy=0` immediately; after release, the first grant with all requesters valid goes to requester 0.
- Round-robin: `p_nreqs=3`, all `req_val=1`, `resp_rdy=1`, messages 0xA/0xB/0xC. Required: `resp_src` sequence 0,1,2,0,1,2 on consecutive cycles, with `resp_msg` 0xA,0xB,0xC,0xA,…
- Backpressure: FULL with `resp_src=1` and `resp_rdy=0` for 4 cycles while requesters 0 and 2 are valid. Required: all `req_rdy=0`, and `resp_msg`/`resp_src` and `prio` hold. When `resp_rdy` rises, requester 2 is granted in that same cycle.
- Simultaneous enqueue/dequeue: FULL with 0x11; `resp_rdy=1` and requester 1 valid with 0x22. Required: the next cycle shows `resp_val=1`, `resp_msg=0x22`, `resp_src=1`; `full` never drops.
- Idle/drain: a single message 0x5 from requester 1, then no `req_val`, with `resp_rdy=1`. Required: `resp_val` is high for exactly one cycle, then 0. `prio` becomes 2 and stays 2 through idle cycles.
- Wrap: `p_nreqs=3` with only requester 2 valid. Required: grant to 2, then `prio=0`; the next grant with requesters 0 and 2 valid goes to 0.
